// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding,
// digit limits, correction constants and a width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // Smallest binary width that can hold 10^digits - 1.
    function automatic int unsigned min_bin_w(input int unsigned digits);
        longint unsigned pow10;
        pow10 = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        return $clog2(pow10);
    endfunction

endpackage

// File: rtl/bcd_nib_adj.sv
// One BCD nibble correction step of reverse double-dabble: subtract 3
// from nibbles that reached 8 or more after the right shift.
module bcd_nib_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= ADJ_THRESH) ? (i_nib - ADJ_VAL) : i_nib;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one bit per clock, with start/busy/done handshake and digit validation.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [BIN_W-1:0]      BIN,
    output logic                  ERR
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = 2 * BCD_W;
    localparam int unsigned CNT_W = $clog2(4 * DIGITS + 1);

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("bcd_to_bin: DIGITS must be in 1..4");
    end
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
        $error("bcd_to_bin: BIN_W too narrow for 10^DIGITS");
    end

    state_e              r_state;
    logic [SR_W-1:0]     r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_bin;
    logic                r_err;

    logic [SR_W-1:0]     w_shift;
    logic [SR_W-1:0]     w_next;
    logic                w_bad;

    // Binary field is BCD_W wide so no bit falls off before the last shift.
    assign w_shift = {1'b0, r_sr[SR_W-1:1]};
    assign w_next[BCD_W-1:0] = w_shift[BCD_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nib_adj u_adj (
            .i_nib   (w_shift[BCD_W + 4*g +: 4]),
            .o_nib_c (w_next[BCD_W + 4*g +: 4])
        );
    end

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (BCD[4*i +: 4] > BCD_MAX) begin
                w_bad = 1'b1;
            end
        end
    end

    // BIN/ERR are loaded on the edge entering FIN so they change with DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_sr  <= {BCD, {BCD_W{1'b0}}};
                        r_cnt <= '0;
                        if (w_bad) begin
                            r_bin   <= '0;
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_state <= CONV;
                        end
                    end
                end
                CONV: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BCD_W - 1)) begin
                        r_bin   <= BIN_W'(w_next[BCD_W-1:0]);
                        r_err   <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = (r_state == CONV);
    assign DONE = (r_state == FIN);
    assign BIN  = r_bin;
    assign ERR  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=2, BIN_W=7).
module tb_bcd_to_bin;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [7:0] BCD;
    logic       BUSY;
    logic       DONE;
    logic [6:0] BIN;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .BCD   (BCD),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .BIN   (BIN),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of two packed digits, or error on a bad nibble.
    function automatic void model(input logic [7:0] b, output int val, output logic err);
        int hi, lo;
        hi  = int'(b[7:4]);
        lo  = int'(b[3:0]);
        err = (hi > 9) || (lo > 9);
        val = err ? 0 : hi * 10 + lo;
    endfunction

    // One conversion: pulse START, measure DONE latency and BUSY cycles.
    task automatic run(input logic [7:0] bcd, input int exp_bin, input logic exp_err,
                       input string tag);
        int lat;
        int busy;
        lat  = 0;
        busy = 0;
        @(negedge CLK);
        BCD   = bcd;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (BUSY) busy++;
            if (DONE) begin
                lat = c;
                break;
            end
            @(negedge CLK);
        end
        chk({tag, "_lat"},  lat,  exp_err ? 1 : 9);
        chk({tag, "_busy"}, busy, exp_err ? 0 : 8);
        chk({tag, "_bin"},  BIN,  exp_bin);
        chk({tag, "_err"},  ERR,  exp_err);
        @(negedge CLK);
        chk({tag, "_done_drop"}, DONE, 0);
    endtask

    initial begin
        int   d1, d2, bin1, bin2;
        int   mval;
        logic merr;

        RST_N = 1'b0;
        START = 1'b0;
        BCD   = 8'h00;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_bin",  BIN,  0);
        chk("rst_err",  ERR,  0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        run(8'h31, 31, 1'b0, "v31");
        run(8'h00, 0,  1'b0, "v00");
        run(8'h99, 99, 1'b0, "v99");
        chk("v99_bits", BIN, 7'b1100011);
        run(8'h3A, 0,  1'b1, "inv3A");
        run(8'h12, 12, 1'b0, "v12_after_err");

        // START held high: back-to-back conversions, BCD changed mid-flight.
        @(negedge CLK);
        BCD   = 8'h07;
        START = 1'b1;
        d1 = 0; d2 = 0; bin1 = -1; bin2 = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (c == 4) BCD = 8'h25;
            if (DONE && d1 == 0) begin
                d1 = c; bin1 = int'(BIN);
            end else if (DONE && d2 == 0) begin
                d2 = c; bin2 = int'(BIN);
                START = 1'b0;
                break;
            end
        end
        START = 1'b0;
        chk("cont_first_done", d1, 9);
        chk("cont_first_bin",  bin1, 7);
        chk("cont_period",     d2 - d1, 10);
        chk("cont_second_bin", bin2, 25);
        repeat (12) @(negedge CLK);
        chk("cont_no_requeue", DONE, 0);

        // Reset asserted in the fourth CONV cycle aborts without DONE.
        @(negedge CLK);
        BCD   = 8'h55;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_busy_before", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_bin",  BIN,  0);
        chk("abort_err",  ERR,  0);
        @(negedge CLK);
        RST_N = 1'b1;
        d1 = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (DONE || BUSY) d1++;
        end
        chk("abort_quiet", d1, 0);
        run(8'h18, 18, 1'b0, "v18_after_abort");

        // Full sweep of every 8-bit pattern against the reference model.
        for (int v = 0; v < 256; v++) begin
            model(8'(v), mval, merr);
            run(8'(v), mval, merr, $sformatf("sweep_%02h", v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
